// File: rtl/udp_pkg.sv
// udp_pkg: shared state encoding and field widths for the UDP application arbiter.
package udp_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_GAP} state_t;
    localparam int GRANT_W = 3;
    localparam int DATA_W  = 32;
    localparam int KEEP_W  = 4;
    localparam int LEN_W   = 16;
    localparam int IP_W    = 32;
    localparam int PORT_W  = 16;
    localparam int CNT_W   = 7;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the lowest requesting index at or after ptr, wrapping modulo N_REQ.
module rr_arbiter
    import udp_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [GRANT_W-1:0] ptr,
    output logic [GRANT_W-1:0] grant_idx,
    output logic               any
);
    localparam int DW = GRANT_W + 1;
    logic [DW-1:0] w_dist;
    logic [DW-1:0] w_best;
    // Distance from ptr decides priority; the smallest distance among requesters wins.
    always_comb begin
        grant_idx = '0;
        w_dist    = '0;
        w_best    = DW'(N_REQ);
        for (int i = 0; i < N_REQ; i++) begin
            w_dist = DW'(i) + ((DW'(i) < {1'b0, ptr}) ? DW'(N_REQ) : '0) - {1'b0, ptr};
            if (req[i] && w_dist < w_best) begin
                w_best    = w_dist;
                grant_idx = GRANT_W'(i);
            end
        end
    end
    assign any = |req;
endmodule

// File: rtl/udp_app_arbiter.sv
// udp_app_arbiter: packet-granular round-robin sharing of the send_top UDP app input,
// with per-packet header latching, forced termination at MAX_WORDS and an inter-packet gap.
module udp_app_arbiter
    import udp_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int GAP_CYCLES = 64,
    parameter int MAX_WORDS  = 64
) (
    input  logic                      clk_32,
    input  logic                      reset_32,
    input  logic                      enable,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [DATA_W*N_REQ-1:0]   req_data,
    input  logic [KEEP_W*N_REQ-1:0]   req_keep,
    input  logic [N_REQ-1:0]          req_last,
    input  logic [LEN_W*N_REQ-1:0]    req_length,
    input  logic [IP_W*N_REQ-1:0]     req_dest_ip,
    input  logic [PORT_W*N_REQ-1:0]   req_dest_port,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      app_valid,
    output logic [DATA_W-1:0]         app_data,
    output logic [KEEP_W-1:0]         app_keep,
    output logic                      app_last,
    input  logic                      app_ready,
    output logic [LEN_W-1:0]          app_length,
    output logic [IP_W-1:0]           app_dest_ip,
    output logic [PORT_W-1:0]         app_dest_port,
    output logic [GRANT_W-1:0]        grant_id,
    output logic                      busy,
    output logic                      pkt_done,
    output logic                      overrun
);
    state_t              r_state, w_next;
    logic [GRANT_W-1:0]  r_rr_ptr, r_grant_id, w_win;
    logic [CNT_W-1:0]    r_word_cnt;
    logic [15:0]         r_gap_cnt;
    logic [LEN_W-1:0]    r_app_length, w_win_length;
    logic [IP_W-1:0]     r_app_dest_ip, w_win_ip;
    logic [PORT_W-1:0]   r_app_dest_port, w_win_port;
    logic                w_any, w_take, w_in_grant, w_accept, w_forced, w_gap_end;
    logic                w_sel_valid, w_sel_last;
    logic [DATA_W-1:0]   w_sel_data;
    logic [KEEP_W-1:0]   w_sel_keep;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req       (req_valid),
        .ptr       (r_rr_ptr),
        .grant_idx (w_win),
        .any       (w_any)
    );

    // Two muxes: the granted source drives the data path, the arbitration winner the header capture.
    always_comb begin
        w_sel_valid  = 1'b0;
        w_sel_last   = 1'b0;
        w_sel_data   = '0;
        w_sel_keep   = '0;
        w_win_length = '0;
        w_win_ip     = '0;
        w_win_port   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant_id == GRANT_W'(i)) begin
                w_sel_valid = req_valid[i];
                w_sel_last  = req_last[i];
                w_sel_data  = req_data[DATA_W*i +: DATA_W];
                w_sel_keep  = req_keep[KEEP_W*i +: KEEP_W];
            end
            if (w_win == GRANT_W'(i)) begin
                w_win_length = req_length[LEN_W*i +: LEN_W];
                w_win_ip     = req_dest_ip[IP_W*i +: IP_W];
                w_win_port   = req_dest_port[PORT_W*i +: PORT_W];
            end
        end
    end

    assign w_in_grant    = r_state == ST_GRANT;
    assign w_forced      = r_word_cnt == CNT_W'(MAX_WORDS - 1);
    assign w_take        = r_state == ST_IDLE && enable && w_any;
    assign w_gap_end     = r_gap_cnt == 16'(GAP_CYCLES - 1);
    assign app_valid     = w_in_grant & w_sel_valid;
    assign app_data      = w_in_grant ? w_sel_data : '0;
    assign app_keep      = w_in_grant ? w_sel_keep : '0;
    assign app_last      = w_in_grant & (w_sel_last | w_forced);
    assign w_accept      = app_valid & app_ready;
    assign pkt_done      = w_accept & app_last;
    assign overrun       = w_accept & w_forced & ~w_sel_last;
    assign req_ready     = (w_in_grant & app_ready) ? N_REQ'(1) << r_grant_id : '0;
    assign busy          = r_state != ST_IDLE;
    assign grant_id      = r_grant_id;
    assign app_length    = r_app_length;
    assign app_dest_ip   = r_app_dest_ip;
    assign app_dest_port = r_app_dest_port;

    always_comb begin
        w_next = r_state;
        if (w_take)
            w_next = ST_GRANT;
        else if (pkt_done)
            w_next = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        else if (r_state == ST_GAP && w_gap_end)
            w_next = ST_IDLE;
    end

    always_ff @(posedge clk_32 or posedge reset_32) begin
        if (reset_32)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk_32 or posedge reset_32) begin
        if (reset_32) begin
            r_rr_ptr        <= '0;
            r_grant_id      <= '0;
            r_word_cnt      <= '0;
            r_gap_cnt       <= '0;
            r_app_length    <= '0;
            r_app_dest_ip   <= '0;
            r_app_dest_port <= '0;
        end else begin
            if (w_take) begin
                r_grant_id      <= w_win;
                r_app_length    <= w_win_length;
                r_app_dest_ip   <= w_win_ip;
                r_app_dest_port <= w_win_port;
                r_word_cnt      <= '0;
                r_rr_ptr        <= (w_win == GRANT_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;
            end
            if (w_accept)
                r_word_cnt <= r_word_cnt + 1'b1;
            r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + 16'd1 : '0;
        end
    end
endmodule

// File: tb/tb_udp_app_arbiter.sv
// tb_udp_app_arbiter: scoreboarded bench with a vector table of single-source packets
// and hand-written sequences for round-robin order, gap timing, enable and reset.
module tb_udp_app_arbiter;
    localparam int N    = 4;
    localparam int GAP  = 64;
    localparam int MAXW = 64;

    logic          clk_32 = 1'b0;
    logic          reset_32 = 1'b0;
    logic          enable;
    logic [N-1:0]  req_valid;
    logic [32*N-1:0] req_data;
    logic [4*N-1:0]  req_keep;
    logic [N-1:0]  req_last;
    logic [16*N-1:0] req_length;
    logic [32*N-1:0] req_dest_ip;
    logic [16*N-1:0] req_dest_port;
    logic [N-1:0]  req_ready;
    logic          app_valid;
    logic [31:0]   app_data;
    logic [3:0]    app_keep;
    logic          app_last;
    logic          app_ready;
    logic [15:0]   app_length;
    logic [31:0]   app_dest_ip;
    logic [15:0]   app_dest_port;
    logic [2:0]    grant_id;
    logic          busy;
    logic          pkt_done;
    logic          overrun;

    udp_app_arbiter #(.N_REQ(N), .GAP_CYCLES(GAP), .MAX_WORDS(MAXW)) dut (
        .clk_32(clk_32), .reset_32(reset_32), .enable(enable),
        .req_valid(req_valid), .req_data(req_data), .req_keep(req_keep), .req_last(req_last),
        .req_length(req_length), .req_dest_ip(req_dest_ip), .req_dest_port(req_dest_port),
        .req_ready(req_ready), .app_valid(app_valid), .app_data(app_data), .app_keep(app_keep),
        .app_last(app_last), .app_ready(app_ready), .app_length(app_length),
        .app_dest_ip(app_dest_ip), .app_dest_port(app_dest_port), .grant_id(grant_id),
        .busy(busy), .pkt_done(pkt_done), .overrun(overrun)
    );

    always #5 clk_32 = ~clk_32;

    typedef struct packed {
        logic [2:0]  src;
        logic [31:0] data;
        logic        last;
        logic        ovr;
    } exp_t;

    typedef struct {
        int src;
        int n;
        bit tog;
        int acc;
        int done;
        int ovr;
    } vec_t;

    logic [32:0] sq [N][$];
    exp_t        sb[$];
    int          acc_cyc[$];
    int          pos[N];
    int          checks = 0, failures = 0;
    int          cyc, n_acc, n_done, n_ovr, seq = 0, acc_src;
    logic        acc_pend, ready_toggle;
    vec_t        vecs[5];

    function automatic logic [31:0] ip_of(int i);
        return 32'h0A00_0100 + 32'(i);
    endfunction
    function automatic logic [15:0] port_of(int i);
        return 16'd5000 + 16'(i);
    endfunction
    function automatic logic [15:0] len_of(int i);
        return 16'd40 + 16'(i);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=expired required=completed", nm);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            logic [32:0] h;
            h = (sq[i].size() != 0) ? sq[i][0] : 33'h0;
            req_valid[i]               = sq[i].size() != 0;
            req_data[32*i +: 32]       = h[31:0];
            req_last[i]                = h[32];
            req_keep[4*i +: 4]         = 4'hF;
            req_length[16*i +: 16]     = len_of(i);
            req_dest_ip[32*i +: 32]    = ip_of(i);
            req_dest_port[16*i +: 16]  = port_of(i);
        end
    endtask

    // Each pushed word also yields its expected beat, including forced termination at MAXW.
    task automatic load(input int s, input int n);
        for (int j = 0; j < n; j++) begin
            logic        last, f;
            logic [31:0] d;
            exp_t        e;
            seq++;
            last = (j == n - 1);
            d    = 32'hA000_0000 | (32'(s) << 24) | 32'(seq);
            sq[s].push_back({last, d});
            f      = last || pos[s] == MAXW - 1;
            e.src  = 3'(s);
            e.data = d;
            e.last = f;
            e.ovr  = f && !last;
            sb.push_back(e);
            pos[s] = f ? 0 : pos[s] + 1;
        end
        drive();
    endtask

    task automatic observe();
        exp_t e;
        cyc++;
        chk("rdy_nongrant", 64'(req_ready & ~(4'b1 << grant_id)), 64'h0);
        if (pkt_done) n_done++;
        if (overrun) n_ovr++;
        acc_pend = app_valid && app_ready;
        if (acc_pend) begin
            n_acc++;
            acc_src = int'(grant_id);
            acc_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual=%0h required=none", app_data);
            end else begin
                e = sb.pop_front();
                chk("beat", {26'b0, grant_id, app_data, app_last, overrun, pkt_done},
                    {26'b0, e.src, e.data, e.last, e.ovr, e.last});
                chk("hdr", {app_dest_ip, app_dest_port, app_length},
                    {ip_of(int'(e.src)), port_of(int'(e.src)), len_of(int'(e.src))});
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk_32);
        observe();
        @(posedge clk_32);
        #1;
        if (acc_pend && sq[acc_src].size() != 0) void'(sq[acc_src].pop_front());
        app_ready = ready_toggle ? ~app_ready : 1'b1;
        drive();
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((sb.size() != 0 || busy) && k < budget) begin
            cycle();
            k++;
        end
        if (k >= budget) fail_now("drain_timeout");
    endtask

    task automatic do_reset();
        reset_32 = 1'b1;
        for (int i = 0; i < N; i++) begin
            sq[i].delete();
            pos[i] = 0;
        end
        sb.delete();
        acc_cyc.delete();
        app_ready    = 1'b1;
        ready_toggle = 1'b0;
        drive();
        repeat (2) @(posedge clk_32);
        #1;
        chk("reset_out", 64'({app_valid, app_data, app_keep, app_last, grant_id, busy, pkt_done, overrun, req_ready}), 64'h0);
        chk("reset_hdr", {app_length, app_dest_ip, app_dest_port}, 64'h0);
        reset_32 = 1'b0;
        cyc = 0; n_acc = 0; n_done = 0; n_ovr = 0; acc_pend = 1'b0;
    endtask

    initial begin
        enable = 1'b1;
        vecs[0] = '{0, 64,  1'b0, 64,  1, 0};
        vecs[1] = '{2, 10,  1'b1, 10,  1, 0};
        vecs[2] = '{1, 70,  1'b0, 70,  2, 1};
        vecs[3] = '{3, 1,   1'b1, 1,   1, 0};
        vecs[4] = '{0, 128, 1'b0, 128, 2, 1};

        for (int v = 0; v < 5; v++) begin
            do_reset();
            ready_toggle = vecs[v].tog;
            load(vecs[v].src, vecs[v].n);
            drain(3000);
            chk($sformatf("v%0d_accepted", v), 64'(n_acc), 64'(vecs[v].acc));
            chk($sformatf("v%0d_pkt_done", v), 64'(n_done), 64'(vecs[v].done));
            chk($sformatf("v%0d_overrun", v), 64'(n_ovr), 64'(vecs[v].ovr));
        end

        // Latency from request to first beat and spacing between back-to-back packets.
        do_reset();
        load(0, 64);
        load(0, 3);
        drain(3000);
        if (acc_cyc.size() == 67) begin
            chk("grant_latency", 64'(acc_cyc[0]), 64'd2);
            chk("gap_spacing", 64'(acc_cyc[64] - acc_cyc[63]), 64'(GAP + 2));
        end else
            chk("gap_beats", 64'(acc_cyc.size()), 64'd67);

        // Simultaneous requesters 0, 1, 3; scoreboard order enforces grants 0,1,3,0.
        do_reset();
        load(0, 4);
        load(1, 4);
        load(3, 4);
        load(0, 4);
        drain(3000);
        chk("rr_pkts", 64'(n_done), 64'd4);
        chk("rr_beats", 64'(n_acc), 64'd16);

        // Enable dropped mid-packet: the packet completes, then nothing is granted.
        do_reset();
        load(0, 10);
        repeat (3) cycle();
        enable = 1'b0;
        load(2, 4);
        repeat (150) cycle();
        chk("en_pkt_done", 64'(n_done), 64'd1);
        chk("en_beats", 64'(n_acc), 64'd10);
        chk("en_idle", 64'(busy), 64'd0);
        chk("en_no_grant", 64'(sq[2].size()), 64'd4);
        enable = 1'b1;
        drain(3000);
        chk("en_resume_beats", 64'(n_acc), 64'd14);

        // Reset on word 5 of a packet from source 2, then 0 must outrank 3.
        do_reset();
        load(2, 10);
        begin
            int k = 0;
            while (n_acc < 4 && k < 100) begin
                cycle();
                k++;
            end
            if (k >= 100) fail_now("reset_wait");
        end
        chk("pre_reset_valid", 64'(app_valid), 64'd1);
        reset_32 = 1'b1;
        #1;
        chk("async_reset_out", 64'({app_valid, app_data, app_keep, app_last, grant_id, busy, pkt_done, overrun, req_ready}), 64'h0);
        chk("async_reset_hdr", {app_length, app_dest_ip, app_dest_port}, 64'h0);
        do_reset();
        load(0, 3);
        load(3, 3);
        drain(3000);
        chk("post_reset_pkts", 64'(n_done), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/udp_app_arbiter.md
# udp_app_arbiter

Packet-granular round-robin arbiter sharing the single 32-bit UDP application input of `send_top` between `N_REQ` data sources in the `clk_32` domain. Each source presents a framed 32-bit stream plus per-packet length, destination IP and destination port. The arbiter grants one source per packet, muxes its beats onto the `send_top` app interface and latches its header fields. It then enforces an inter-packet gap before re-arbitrating.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `GAP_CYCLES`, 64: idle cycles inserted after each packet's last beat (0 allowed).
- `MAX_WORDS`, 64: maximum beats per packet before forced termination.
- `clk_32` in 1: system clock.
- `reset_32` in 1: reset, asynchronous, active-high; clock `clk_32`.
- `enable` in 1: permits new grants; does not abort a packet in flight.
- `req_valid` in N_REQ: per-source beat valid.
- `req_data` in 32*N_REQ: per-source data; source i at [32i+31:32i].
- `req_keep` in 4*N_REQ: per-source byte enables.
- `req_last` in N_REQ: per-source end of packet.
- `req_length` in 16*N_REQ: per-source packet byte length; sampled at grant.
- `req_dest_ip` in 32*N_REQ: per-source destination IP; sampled at grant.
- `req_dest_port` in 16*N_REQ: per-source destination port; sampled at grant.
- `req_ready` out N_REQ: per-source ready; only the granted bit is ever high.
- `app_valid` out 1: to `udp_from_app_valid`.
- `app_data` out 32: to `udp_from_app_data`.
- `app_keep` out 4: to `udp_from_app_keep`.
- `app_last` out 1: to `udp_from_app_last`.
- `app_ready` in 1: from `udp_to_app_ready`.
- `app_length` out 16: to `data_from_app_length`.
- `app_dest_ip` out 32: to `dest_ip_addr`.
- `app_dest_port` out 16: to `dest_port`.
- `grant_id` out 3: index of the current or most recent grant.
- `busy` out 1: high in GRANT and GAP.
- `pkt_done` out 1: one-cycle pulse on each accepted last beat, including forced ones.
- `overrun` out 1: one-cycle pulse when a packet is force-terminated at `MAX_WORDS`.

## Operation
- States: IDLE, GRANT, GAP.
- IDLE: if `enable` and any `req_valid` bit is set, select the winner by round-robin.
  - Search starts at `rr_ptr`; after reset `rr_ptr` = 0.
  - Register `grant_id`, `app_length`, `app_dest_ip` and `app_dest_port` from the winner.
  - Clear `word_cnt` and move to GRANT.
  - Set `rr_ptr` to winner+1, modulo `N_REQ`.
- GRANT: combinational mux from source `g` = `grant_id`:
  - `app_valid` = `req_valid[g]`; `app_data`/`app_keep` from source g.
  - `req_ready[g]` = `app_ready`.
  - `app_last` = `req_last[g]` OR (`word_cnt` == `MAX_WORDS`-1).
- A beat is accepted when `app_valid` and `app_ready` are both high; `word_cnt` then increments (7 bits, saturation unnecessary).
- On an accepted beat with `app_last` high:
  - Pulse `pkt_done`.
  - If the last was forced and `req_last[g]` was low, also pulse `overrun`.
  - Go to GAP if `GAP_CYCLES` > 0, else to IDLE.
- After a forced termination, the source's remaining beats form a new packet in a later grant.
- GAP: `gap_cnt` counts 0..`GAP_CYCLES`-1, then the state returns to IDLE.
- `enable` low in GRANT has no effect; it only blocks the IDLE→GRANT transition.
- A non-granted source holding `req_valid` is never acknowledged.
- Header outputs hold their values until the next grant.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, `grant_id` 0, all `app_*` 0, `req_ready` 0, `busy` 0, `pkt_done` 0, `overrun` 0, counters 0.
- Reset mid-packet aborts the packet; no beat is accepted during reset. The source must restart its frame.
- Grant latency: a request seen in IDLE at edge n gives `app_valid` from cycle n+1.
- The data path has zero latency (combinational through the mux); there is no buffering.
- Packet-to-packet spacing is `GAP_CYCLES` + 1 cycles from the accepted last beat to the next possible first beat: the GAP cycles plus one IDLE arbitration cycle.
- When several sources request simultaneously, the lowest index at or after `rr_ptr` wins.
- A single active source is re-granted after each gap.

## Structure
- Shared package `udp_pkg`: state encoding, `GRANT_W` = 3, and the width constants 32, 4, 16 and 32.
- Sub-module `rr_arbiter`:
  - Inputs: `req` [N_REQ], `ptr`.
  - Outputs: `grant_idx`, `any`.
  - Purely combinational; instantiated once.
- Everything else (FSM, counters, mux, header registers) lives in the top.

## Test plan
- Source 0 sends 64 words with last on word 64 and `app_ready` always high → 64 accepted beats, one `pkt_done`, no `overrun`; `app_valid` is low for 65 cycles afterwards with `GAP_CYCLES`=64.
- Sources 0, 1 and 3 request simultaneously with 4-word packets → grants follow the order 0, 1, 3, then 0; each packet's `app_dest_ip`/`app_dest_port` match its source.
- `app_ready` is toggled 1/0 every cycle during a 10-word packet → exactly 10 accepted beats with data order preserved; `req_ready` of non-granted sources stays 0.
- A source sends 70 words with no last before word 70 → beat 64 carries `app_last`=1 and `overrun` pulses; after the gap the remaining 6 words go out as a new packet.
- `enable` is dropped mid-packet → the packet completes; no new grant occurs while `enable`=0.
- `reset_32` is asserted on word 5 of a packet → all outputs are 0 within the same cycle; after release source 0 is highest priority.
